probability_table_updater: RTL and testbench

- Write-side companion of the ANS probability lookup.
- Accepts decoded (context, symbol) events over a valid/ready handshake and maintains an adaptive per-context frequency model in a shadow count table.
- Emits one table-write command per changed entry so the lookup table's prob_table tracks the shadow copy.
- Initialises the table to uniform after reset, and halves a whole context when its total or any single count would overflow.

---
 rtl/ans_pkg.sv | 27 ++
 rtl/probability_table_updater_if.sv | 33 +++
 rtl/prob_count_store.sv | 37 +++
 rtl/probability_table_updater.sv | 144 ++++++++++++++
 tb/tb_probability_table_updater.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ans_pkg.sv
// Shared types and default sizing for the ANS probability table updater.
// The width helpers keep the top and the count store agreeing on derived widths.
package ans_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CHECK,
    WRITE,
    RESCALE
  } state_t;

  localparam int DEF_CONTEXT_WIDTH = 4;
  localparam int DEF_PROB_WIDTH    = 8;
  localparam int DEF_NUM_SYMBOLS   = 16;
  localparam int DEF_NUM_CONTEXTS  = 16;
  localparam int DEF_TOTAL_LIMIT   = 2048;

  function automatic int sym_width(input int num_symbols);
    return (num_symbols > 1) ? $clog2(num_symbols) : 1;
  endfunction

  function automatic int tot_width(input int prob_width, input int num_symbols);
    return prob_width + sym_width(num_symbols);
  endfunction

endpackage

// File: rtl/probability_table_updater_if.sv
// Update-event handshake plus table-write command bus of the probability updater.
// The updater sits on the slave side; the decoder/lookup environment on the master side.
interface probability_table_updater_if
  import ans_pkg::*;
#(
  parameter int CONTEXT_WIDTH = DEF_CONTEXT_WIDTH,
  parameter int SYM_WIDTH     = sym_width(DEF_NUM_SYMBOLS),
  parameter int PROB_WIDTH    = DEF_PROB_WIDTH
);
  logic                     upd_valid;
  logic                     upd_ready;
  logic [CONTEXT_WIDTH-1:0] upd_context;
  logic [SYM_WIDTH-1:0]     upd_symbol;
  logic                     wr_en;
  logic [CONTEXT_WIDTH-1:0] wr_context;
  logic [SYM_WIDTH-1:0]     wr_symbol;
  logic [PROB_WIDTH-1:0]    wr_data;
  logic                     init_done;
  logic                     rescale_active;
  logic                     err_pulse;

  modport slave (
    input  upd_valid, upd_context, upd_symbol,
    output upd_ready, wr_en, wr_context, wr_symbol, wr_data,
           init_done, rescale_active, err_pulse
  );

  modport master (
    output upd_valid, upd_context, upd_symbol,
    input  upd_ready, wr_en, wr_context, wr_symbol, wr_data,
           init_done, rescale_active, err_pulse
  );
endinterface

// File: rtl/prob_count_store.sv
// Shadow copy of the per-context symbol counts and their running totals.
// Combinational read of one (ctx,sym) entry; a single registered write updates count and total together.
module prob_count_store
  import ans_pkg::*;
#(
  parameter int CONTEXT_WIDTH = DEF_CONTEXT_WIDTH,
  parameter int SYM_WIDTH     = sym_width(DEF_NUM_SYMBOLS),
  parameter int PROB_WIDTH    = DEF_PROB_WIDTH,
  parameter int TOT_WIDTH     = tot_width(DEF_PROB_WIDTH, DEF_NUM_SYMBOLS),
  parameter int NUM_CONTEXTS  = DEF_NUM_CONTEXTS,
  parameter int NUM_SYMBOLS   = DEF_NUM_SYMBOLS
) (
  input  logic                     clk,
  input  logic [CONTEXT_WIDTH-1:0] i_rdCtx,
  input  logic [SYM_WIDTH-1:0]     i_rdSym,
  output logic [PROB_WIDTH-1:0]    o_rdCount,
  output logic [TOT_WIDTH-1:0]     o_rdTotal,
  input  logic                     i_we,
  input  logic [CONTEXT_WIDTH-1:0] i_wrCtx,
  input  logic [SYM_WIDTH-1:0]     i_wrSym,
  input  logic [PROB_WIDTH-1:0]    i_wrCount,
  input  logic [TOT_WIDTH-1:0]     i_wrTotal
);
  logic [PROB_WIDTH-1:0] r_count [NUM_CONTEXTS][NUM_SYMBOLS];
  logic [TOT_WIDTH-1:0]  r_total [NUM_CONTEXTS];

  assign o_rdCount = r_count[i_rdCtx][i_rdSym];
  assign o_rdTotal = r_total[i_rdCtx];

  // Contents are defined by the INIT sweep, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_count[i_wrCtx][i_wrSym] <= i_wrCount;
      r_total[i_wrCtx]          <= i_wrTotal;
    end
  end
endmodule

// File: rtl/probability_table_updater.sv
// Adaptive frequency model: counts decoded (context,symbol) events and mirrors every
// changed count to the lookup table, halving a context before any count or total overflows.
module probability_table_updater
  import ans_pkg::*;
#(
  parameter int CONTEXT_WIDTH = DEF_CONTEXT_WIDTH,
  parameter int PROB_WIDTH    = DEF_PROB_WIDTH,
  parameter int NUM_SYMBOLS   = DEF_NUM_SYMBOLS,
  parameter int NUM_CONTEXTS  = DEF_NUM_CONTEXTS,
  parameter int TOTAL_LIMIT   = DEF_TOTAL_LIMIT
) (
  input logic clk,
  input logic rst_n,
  probability_table_updater_if.slave bus
);
  localparam int SYM_WIDTH = sym_width(NUM_SYMBOLS);
  localparam int TOT_WIDTH = tot_width(PROB_WIDTH, NUM_SYMBOLS);
  localparam logic [PROB_WIDTH-1:0]    MAX_COUNT = '1;
  localparam logic [TOT_WIDTH:0]       LIMIT     = (TOT_WIDTH+1)'(TOTAL_LIMIT);
  localparam logic [CONTEXT_WIDTH-1:0] LAST_CTX  = CONTEXT_WIDTH'(NUM_CONTEXTS - 1);
  localparam logic [SYM_WIDTH-1:0]     LAST_SYM  = SYM_WIDTH'(NUM_SYMBOLS - 1);

  state_t                   r_state, w_next;
  logic                     r_armed, r_initDone, r_errPulse;
  logic [CONTEXT_WIDTH-1:0] r_initCtx, r_evCtx;
  logic [SYM_WIDTH-1:0]     r_initSym, r_evSym, r_resSym;
  logic [TOT_WIDTH-1:0]     r_resAcc;

  logic                     w_accept, w_inRange, w_needRescale, w_we;
  logic [SYM_WIDTH-1:0]     w_rdSym, w_wrSym;
  logic [CONTEXT_WIDTH-1:0] w_wrCtx;
  logic [PROB_WIDTH-1:0]    w_rdCount, w_wrCount, w_halved;
  logic [PROB_WIDTH:0]      w_countInc;
  logic [TOT_WIDTH-1:0]     w_rdTotal, w_wrTotal, w_accBase, w_accNext;
  logic [TOT_WIDTH:0]       w_totalInc;

  prob_count_store #(
    .CONTEXT_WIDTH(CONTEXT_WIDTH), .SYM_WIDTH(SYM_WIDTH), .PROB_WIDTH(PROB_WIDTH),
    .TOT_WIDTH(TOT_WIDTH), .NUM_CONTEXTS(NUM_CONTEXTS), .NUM_SYMBOLS(NUM_SYMBOLS)
  ) u_store (
    .clk(clk), .i_rdCtx(r_evCtx), .i_rdSym(w_rdSym), .o_rdCount(w_rdCount), .o_rdTotal(w_rdTotal),
    .i_we(w_we), .i_wrCtx(w_wrCtx), .i_wrSym(w_wrSym), .i_wrCount(w_wrCount), .i_wrTotal(w_wrTotal)
  );

  assign w_accept  = bus.upd_valid && (r_state == IDLE);
  assign w_inRange = ({1'b0, bus.upd_context} < (CONTEXT_WIDTH+1)'(NUM_CONTEXTS)) &&
                     ({1'b0, bus.upd_symbol} < (SYM_WIDTH+1)'(NUM_SYMBOLS));
  assign w_rdSym   = (r_state == RESCALE) ? r_resSym : r_evSym;

  // Rounding-up halve keeps every count at least 1; the total is rebuilt as the sweep runs.
  assign w_countInc    = {1'b0, w_rdCount} + (PROB_WIDTH+1)'(1);
  assign w_halved      = w_countInc[PROB_WIDTH:1];
  assign w_totalInc    = {1'b0, w_rdTotal} + (TOT_WIDTH+1)'(1);
  assign w_needRescale = (w_rdCount == MAX_COUNT) || (w_totalInc > LIMIT);
  assign w_accBase     = (r_resSym == '0) ? '0 : r_resAcc;
  assign w_accNext     = w_accBase + TOT_WIDTH'(w_halved);

  // r_armed holds off the INIT writes until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_armed    <= 1'b0;
      r_initCtx  <= '0;
      r_initSym  <= '0;
      r_evCtx    <= '0;
      r_evSym    <= '0;
      r_resSym   <= '0;
      r_resAcc   <= '0;
      r_initDone <= 1'b0;
      r_errPulse <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_armed    <= 1'b1;
      r_errPulse <= w_accept && !w_inRange;
      if (r_state == INIT && r_armed) begin
        if (r_initSym == LAST_SYM) begin
          r_initSym <= '0;
          r_initCtx <= r_initCtx + CONTEXT_WIDTH'(1);
          if (r_initCtx == LAST_CTX) r_initDone <= 1'b1;
        end else begin
          r_initSym <= r_initSym + SYM_WIDTH'(1);
        end
      end
      if (w_accept && w_inRange) begin
        r_evCtx <= bus.upd_context;
        r_evSym <= bus.upd_symbol;
      end
      if (r_state == CHECK) r_resSym <= '0;
      if (r_state == RESCALE) begin
        r_resSym <= (r_resSym == LAST_SYM) ? '0 : r_resSym + SYM_WIDTH'(1);
        r_resAcc <= w_accNext;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_we      = 1'b0;
    w_wrCtx   = '0;
    w_wrSym   = '0;
    w_wrCount = '0;
    w_wrTotal = '0;
    case (r_state)
      INIT: begin
        if (r_armed) begin
          w_we      = 1'b1;
          w_wrCtx   = r_initCtx;
          w_wrSym   = r_initSym;
          w_wrCount = PROB_WIDTH'(1);
          w_wrTotal = TOT_WIDTH'(NUM_SYMBOLS);
          if (r_initCtx == LAST_CTX && r_initSym == LAST_SYM) w_next = IDLE;
        end
      end
      IDLE:  if (w_accept && w_inRange) w_next = CHECK;
      CHECK: w_next = w_needRescale ? RESCALE : WRITE;
      WRITE: begin
        w_we      = 1'b1;
        w_wrCtx   = r_evCtx;
        w_wrSym   = r_evSym;
        w_wrCount = w_countInc[PROB_WIDTH-1:0];
        w_wrTotal = w_totalInc[TOT_WIDTH-1:0];
        w_next    = IDLE;
      end
      RESCALE: begin
        w_we      = 1'b1;
        w_wrCtx   = r_evCtx;
        w_wrSym   = r_resSym;
        w_wrCount = w_halved;
        w_wrTotal = w_accNext;
        if (r_resSym == LAST_SYM) w_next = CHECK;
      end
      default: w_next = INIT;
    endcase
  end

  assign bus.upd_ready      = (r_state == IDLE);
  assign bus.rescale_active = (r_state == RESCALE);
  assign bus.init_done      = r_initDone;
  assign bus.err_pulse      = r_errPulse;
  assign bus.wr_en          = w_we;
  assign bus.wr_context     = w_wrCtx;
  assign bus.wr_symbol      = w_wrSym;
  assign bus.wr_data        = w_wrCount;
endmodule

// File: tb/tb_probability_table_updater.sv
// Directed bench for probability_table_updater: vector table for plain updates,
// hand-written sequences for init, rescale, overflow of the total, range errors and reset.
module tb_probability_table_updater;
  import ans_pkg::*;

  localparam int CW = 4;
  localparam int SW = 4;
  localparam int PW = 8;
  localparam int NS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  probability_table_updater_if #(.CONTEXT_WIDTH(CW), .SYM_WIDTH(SW), .PROB_WIDTH(PW)) bus ();
  probability_table_updater_if #(.CONTEXT_WIDTH(CW), .SYM_WIDTH(SW), .PROB_WIDTH(PW)) bus12 ();

  probability_table_updater #(
    .CONTEXT_WIDTH(CW), .PROB_WIDTH(PW), .NUM_SYMBOLS(NS), .NUM_CONTEXTS(16), .TOTAL_LIMIT(2048)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  probability_table_updater #(
    .CONTEXT_WIDTH(CW), .PROB_WIDTH(PW), .NUM_SYMBOLS(NS), .NUM_CONTEXTS(12), .TOTAL_LIMIT(2048)
  ) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12.slave));

  typedef struct {
    logic [3:0] ctx;
    logic [3:0] sym;
    logic [7:0] data;
    int         cyc;
  } wr_rec_t;

  typedef struct {
    logic [3:0] ctx;
    logic [3:0] sym;
    logic [7:0] expData;
  } vec_t;

  int      checksRun = 0;
  int      checksPassed = 0;
  int      cyc = 0;
  int      rescaleCnt = 0;
  wr_rec_t wq[$];

  always @(posedge clk) cyc++;

  // Write/rescale capture on the main DUT, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en) wq.push_back('{bus.wr_context, bus.wr_symbol, bus.wr_data, cyc});
    if (bus.rescale_active) rescaleCnt++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checksRun++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic wr_rec_t getRec(input int i);
    wr_rec_t r;
    r = '{4'h0, 4'h0, 8'h0, -100};
    if (i < wq.size()) r = wq[i];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where upd_ready is back high.
  task automatic applyStimulus(input logic [3:0] ctx, input logic [3:0] sym,
                               output int lowCycles, output int acceptCyc);
    int n;
    n = 0;
    while (!bus.upd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.upd_ready) checkOutput("ready_timeout", {63'd0, bus.upd_ready}, 64'd1);
    wq.delete();
    rescaleCnt = 0;
    bus.upd_valid   = 1'b1;
    bus.upd_context = ctx;
    bus.upd_symbol  = sym;
    @(posedge clk);
    #1 acceptCyc = cyc;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    lowCycles = 0;
    while (!bus.upd_ready && lowCycles < 100) begin
      lowCycles++;
      @(negedge clk);
    end
    if (!bus.upd_ready) checkOutput("done_timeout", {63'd0, bus.upd_ready}, 64'd1);
  endtask

  // Called at the negedge of reset release; walks the whole uniform sweep.
  task automatic checkInit(input string tag);
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      checkOutput($sformatf("%s_entry_%0d", tag, i),
                  {45'd0, bus.wr_en, bus.wr_context, bus.wr_symbol, bus.wr_data, bus.init_done, bus.upd_ready},
                  {45'd0, 1'b1, 4'(i / 16), 4'(i % 16), 8'd1, 1'b0, 1'b0});
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, {61'd0, bus.init_done, bus.upd_ready, bus.wr_en}, 64'b110);
  endtask

  initial begin
    vec_t    vecs[7];
    wr_rec_t rec;
    int      low, acc, sum, bad, rescaleSum, n;
    logic [7:0] lastData;

    vecs[0] = '{4'd3,  4'd5,  8'd2};
    vecs[1] = '{4'd3,  4'd5,  8'd3};
    vecs[2] = '{4'd0,  4'd0,  8'd2};
    vecs[3] = '{4'd15, 4'd15, 8'd2};
    vecs[4] = '{4'd3,  4'd6,  8'd2};
    vecs[5] = '{4'd3,  4'd5,  8'd4};
    vecs[6] = '{4'd9,  4'd1,  8'd2};

    bus.upd_valid = 1'b0;   bus.upd_context = '0;   bus.upd_symbol = '0;
    bus12.upd_valid = 1'b0; bus12.upd_context = '0; bus12.upd_symbol = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {44'd0, bus.wr_en, bus.wr_context, bus.wr_symbol, bus.wr_data,
                 bus.init_done, bus.rescale_active, bus.err_pulse, bus.upd_ready}, 64'd0);
    rst_n = 1'b1;
    checkInit("init");

    // Plain updates: one write two cycles after accept, ready low for two cycles.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].ctx, vecs[v].sym, low, acc);
      rec = getRec(0);
      checkOutput($sformatf("vec%0d_nwrites", v), 64'(wq.size()), 64'd1);
      checkOutput($sformatf("vec%0d_write", v), {48'd0, rec.ctx, rec.sym, rec.data},
                  {48'd0, vecs[v].ctx, vecs[v].sym, vecs[v].expData});
      checkOutput($sformatf("vec%0d_latency", v), 64'(rec.cyc - acc + 1), 64'd2);
      checkOutput($sformatf("vec%0d_ready_low", v), 64'(low), 64'd2);
    end

    // Event held across the busy window is taken only once ready returns.
    wq.delete();
    bus.upd_valid = 1'b1; bus.upd_context = 4'd4; bus.upd_symbol = 4'd4;
    @(negedge clk);
    bus.upd_symbol = 4'd9;
    n = 0;
    while (!bus.upd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.upd_valid = 1'b0;
    n = 0;
    while (!bus.upd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("held_nwrites", 64'(wq.size()), 64'd2);
    rec = getRec(0);
    checkOutput("held_first", {48'd0, rec.ctx, rec.sym, rec.data}, {48'd0, 4'd4, 4'd4, 8'd2});
    rec = getRec(1);
    checkOutput("held_second", {48'd0, rec.ctx, rec.sym, rec.data}, {48'd0, 4'd4, 4'd9, 8'd2});

    // Count saturation: 254 events bring ctx7/sym0 to 255, the next one rescales.
    rescaleSum = 0;
    lastData = '0;
    for (int i = 0; i < 254; i++) begin
      applyStimulus(4'd7, 4'd0, low, acc);
      rescaleSum += rescaleCnt;
      lastData = getRec(0).data;
    end
    checkOutput("sat_no_early_rescale", 64'(rescaleSum), 64'd0);
    checkOutput("sat_count_255", {56'd0, lastData}, 64'd255);
    applyStimulus(4'd7, 4'd0, low, acc);
    checkOutput("sat_rescale_cycles", 64'(rescaleCnt), 64'd16);
    checkOutput("sat_nwrites", 64'(wq.size()), 64'd17);
    rec = getRec(0);
    checkOutput("sat_sym0_halved", {48'd0, rec.ctx, rec.sym, rec.data}, {48'd0, 4'd7, 4'd0, 8'd128});
    bad = 0;
    for (int s = 1; s < 16; s++) begin
      rec = getRec(s);
      if (rec.ctx != 4'd7 || rec.sym != 4'(s) || rec.data != 8'd1) bad++;
    end
    checkOutput("sat_others_one", 64'(bad), 64'd0);
    rec = getRec(16);
    checkOutput("sat_final_write", {48'd0, rec.ctx, rec.sym, rec.data}, {48'd0, 4'd7, 4'd0, 8'd129});
    checkOutput("sat_latency", 64'(rec.cyc - acc + 1), 64'd19);

    // Total overflow: 127 events per symbol lift total[2] to exactly 2048.
    rescaleSum = 0;
    for (int i = 0; i < 2032; i++) begin
      applyStimulus(4'd2, 4'(i % 16), low, acc);
      rescaleSum += rescaleCnt;
      lastData = getRec(0).data;
    end
    checkOutput("tot_no_early_rescale", 64'(rescaleSum), 64'd0);
    checkOutput("tot_last_count", {56'd0, lastData}, 64'd128);
    applyStimulus(4'd2, 4'd0, low, acc);
    checkOutput("tot_rescale_cycles", 64'(rescaleCnt), 64'd16);
    checkOutput("tot_nwrites", 64'(wq.size()), 64'd17);
    sum = 0;
    bad = 0;
    for (int s = 0; s < 16; s++) begin
      rec = getRec(s);
      sum += int'(rec.data);
      if (rec.ctx != 4'd2 || rec.sym != 4'(s) || rec.data != 8'd64) bad++;
    end
    checkOutput("tot_halved_entries", 64'(bad), 64'd0);
    checkOutput("tot_halved_sum", 64'(sum), 64'd1024);
    checkOutput("tot_bound", {63'd0, (sum + 1) <= (2048 / 2 + 16 + 1)}, 64'd1);
    rec = getRec(16);
    checkOutput("tot_final_write", {48'd0, rec.ctx, rec.sym, rec.data}, {48'd0, 4'd2, 4'd0, 8'd65});

    // Out-of-range contexts on the 12-context instance.
    for (int k = 0; k < 2; k++) begin
      bus12.upd_valid = 1'b1;
      bus12.upd_context = (k == 0) ? 4'd13 : 4'd12;
      bus12.upd_symbol = 4'd0;
      @(negedge clk);
      bus12.upd_valid = 1'b0;
      checkOutput($sformatf("err%0d_pulse", k), {61'd0, bus12.err_pulse, bus12.wr_en, bus12.upd_ready}, 64'b101);
      @(negedge clk);
      checkOutput($sformatf("err%0d_after", k), {61'd0, bus12.err_pulse, bus12.wr_en, bus12.upd_ready}, 64'b001);
    end
    bus12.upd_valid = 1'b1; bus12.upd_context = 4'd11; bus12.upd_symbol = 4'd4;
    @(negedge clk);
    bus12.upd_valid = 1'b0;
    checkOutput("err_next_check", {62'd0, bus12.upd_ready, bus12.wr_en}, 64'b00);
    @(negedge clk);
    checkOutput("err_next_write", {47'd0, bus12.wr_en, bus12.wr_context, bus12.wr_symbol, bus12.wr_data},
                {47'd0, 1'b1, 4'd11, 4'd4, 8'd2});
    @(negedge clk);
    checkOutput("err_next_ready", {63'd0, bus12.upd_ready}, 64'd1);

    // Reset in the middle of a rescale sweep of ctx7 (sym0 is 129 -> 255 after 126 events).
    for (int i = 0; i < 126; i++) begin
      applyStimulus(4'd7, 4'd0, low, acc);
      lastData = getRec(0).data;
    end
    checkOutput("mid_count_255", {56'd0, lastData}, 64'd255);
    bus.upd_valid = 1'b1; bus.upd_context = 4'd7; bus.upd_symbol = 4'd0;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    n = 0;
    while (!bus.rescale_active && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checkOutput("mid_in_rescale", {63'd0, bus.rescale_active}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_outputs",
                {44'd0, bus.wr_en, bus.wr_context, bus.wr_symbol, bus.wr_data,
                 bus.init_done, bus.rescale_active, bus.err_pulse, bus.upd_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkInit("reinit");
    applyStimulus(4'd7, 4'd0, low, acc);
    rec = getRec(0);
    checkOutput("reinit_ctx7_sym0", {48'd0, rec.ctx, rec.sym, rec.data}, {48'd0, 4'd7, 4'd0, 8'd2});
    applyStimulus(4'd7, 4'd1, low, acc);
    rec = getRec(0);
    checkOutput("reinit_ctx7_sym1", {48'd0, rec.ctx, rec.sym, rec.data}, {48'd0, 4'd7, 4'd1, 8'd2});

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end
endmodule
